seg_scan_controller: RTL and testbench

Time-multiplexing scheduler that shares one `SevenSegmentDisplay` decoder among `DIGITS` common-anode digits. Holds a frame of 4-bit digit codes, drives the decoder input with one digit per scan slot, and enables the matching anode after a blanking interval to prevent ghosting. Sits between the counter datapath (value source) and the decoder/segment pins. New values are committed only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seg_scan_controller_if.sv | 26 ++
 rtl/seg_scan_controller.sv | 138 +++++++++++++
 tb/tb_seg_scan_controller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_controller_if.sv
// Scan controller bus: value source strobes in, decoder/anode drive out.
// Latency: none, wires only.
// Backpressure: none; load is a single-cycle strobe with no ready.
interface seg_scan_controller_if #(
   parameter int DIGITS = 4
);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic                  enable;
   logic                  load;
   logic [4*DIGITS-1:0]   digit_data;
   logic [3:0]            decoder_in;
   logic [DIGITS-1:0]     anode;
   logic [IW-1:0]         digit_idx;
   logic                  frame_done;

   modport master (
      output enable, load, digit_data,
      input  decoder_in, anode, digit_idx, frame_done
   );

   modport slave (
      input  enable, load, digit_data,
      output decoder_in, anode, digit_idx, frame_done
   );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed digit scanner sharing one 7-segment decoder; optional LEADING_ZERO_BLANK_EN.
// Latency: all outputs registered; anode lights BLANK_CYC cycles after each slot start.
// Backpressure: none; enable low drops to IDLE next cycle, loads apply at the next frame.
module seg_scan_controller #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   seg_scan_controller_if.slave  bus
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t              state_q, state_nxt;
   logic [CW-1:0]       cnt_q, cnt_nxt;
   logic [IW-1:0]       idx_q, idx_nxt;
   logic [4*DIGITS-1:0] pending_q, pending_nxt;
   logic [4*DIGITS-1:0] active_q, active_nxt;
   logic [DIGITS-1:0]   anode_q, anode_nxt;
   logic [3:0]          dec_q, dec_nxt;
   logic                fd_q, fd_nxt;
   logic                start_frame;
   logic [DIGITS-1:0]   show_mask;

   function automatic logic [3:0] pick(input logic [4*DIGITS-1:0] v, input logic [IW-1:0] i);
      pick = 4'h0;
      for (int k = 0; k < DIGITS; k++) begin
         if (i == IW'(k)) pick = v[4*k +: 4];
      end
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   // Walk down from the top digit; everything from the first nonzero digit on is lit.
   always_comb begin
      logic seen_nz;
      seen_nz   = 1'b0;
      show_mask = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if ((active_q[4*k +: 4] != 4'h0) || (k == 0)) seen_nz = 1'b1;
         show_mask[k] = seen_nz;
      end
   end
`else
   assign show_mask = '1;
`endif

   always_comb begin
      state_nxt   = state_q;
      cnt_nxt     = cnt_q;
      idx_nxt     = idx_q;
      active_nxt  = active_q;
      dec_nxt     = dec_q;
      start_frame = 1'b0;
      pending_nxt = bus.load ? bus.digit_data : pending_q;

      if (!bus.enable) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         idx_nxt   = '0;
         dec_nxt   = 4'h0;
      end else begin
         case (state_q)
            IDLE: start_frame = 1'b1;
            default: begin
               if (cnt_q == CNT_LAST) begin
                  if (idx_q == IDX_LAST) begin
                     start_frame = 1'b1;
                  end else begin
                     idx_nxt   = idx_q + IW'(1);
                     cnt_nxt   = '0;
                     state_nxt = BLANK;
                     dec_nxt   = pick(active_q, idx_q + IW'(1));
                  end
               end else begin
                  cnt_nxt   = cnt_q + CW'(1);
                  state_nxt = (cnt_nxt >= CNT_SHOW) ? SHOW : BLANK;
               end
            end
         endcase

         // A load coinciding with the frame start goes straight to the active frame.
         if (start_frame) begin
            active_nxt = bus.load ? bus.digit_data : pending_q;
            idx_nxt    = '0;
            cnt_nxt    = '0;
            state_nxt  = BLANK;
            dec_nxt    = active_nxt[3:0];
         end
      end

      anode_nxt = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if ((state_nxt == SHOW) && (idx_nxt == IW'(k)) && show_mask[k]) anode_nxt[k] = 1'b0;
      end

      fd_nxt = (state_nxt != IDLE) && (idx_nxt == IDX_LAST) && (cnt_nxt == CNT_LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         pending_q <= '0;
         active_q  <= '0;
         anode_q   <= '1;
         dec_q     <= 4'h0;
         fd_q      <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         idx_q     <= idx_nxt;
         pending_q <= pending_nxt;
         active_q  <= active_nxt;
         anode_q   <= anode_nxt;
         dec_q     <= dec_nxt;
         fd_q      <= fd_nxt;
      end
   end

   assign bus.anode      = anode_q;
   assign bus.decoder_in = dec_q;
   assign bus.digit_idx  = idx_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// Table rows drive inputs for one edge, idle for the rest, then check all outputs.
module tb_seg_scan_controller;
   localparam int DIGITS    = 4;
   localparam int SCAN_DIV  = 8;
   localparam int BLANK_CYC = 2;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_scan_controller_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_controller #(
      .DIGITS    (DIGITS),
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        en;
      logic        ld;
      logic [15:0] dat;
      int          adv;
      logic [3:0]  dec;
      logic [3:0]  an;
      logic [1:0]  idx;
      logic        fd;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic vec_t mk(input logic en, input logic ld, input logic [15:0] dat, input int adv,
                               input logic [3:0] dec, input logic [3:0] an, input logic [1:0] idx,
                               input logic fd);
      vec_t r;
      r.en = en; r.ld = ld; r.dat = dat; r.adv = adv;
      r.dec = dec; r.an = an; r.idx = idx; r.fd = fd;
      return r;
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic check_outs(input string tag, input logic [3:0] dec, input logic [3:0] an,
                             input logic [1:0] idx, input logic fd);
      check({tag, ".decoder_in"}, 16'(bus.decoder_in), 16'(dec));
      check({tag, ".anode"},      16'(bus.anode),      16'(an));
      check({tag, ".digit_idx"},  16'(bus.digit_idx),  16'(idx));
      check({tag, ".frame_done"}, 16'(bus.frame_done), 16'(fd));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int pulses;
      int first_fd;
      int last_fd;

      bus.enable     = 1'b0;
      bus.load       = 1'b0;
      bus.digit_data = 16'h0000;

      // Basic scan, tear-free mid-frame load, wrap-edge load, enable drop, zero-digit patterns.
      tbl.push_back(mk(0, 1, 16'h1234, 1, 4'h0, 4'hF, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 4'h4, 4'hF, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 4'h4, 4'hF, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 4'h4, 4'hE, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 5, 4'h4, 4'hE, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 4'h3, 4'hF, 2'd1, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 2, 4'h3, 4'hD, 2'd1, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 6, 4'h2, 4'hF, 2'd2, 0));
      tbl.push_back(mk(1, 1, 16'h5678, 2, 4'h2, 4'hB, 2'd2, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 6, 4'h1, 4'hF, 2'd3, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 2, 4'h1, 4'h7, 2'd3, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 5, 4'h1, 4'h7, 2'd3, 1));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 4'h8, 4'hF, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 2, 4'h8, 4'hE, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 6, 4'h7, 4'hF, 2'd1, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 8, 4'h6, 4'hF, 2'd2, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 8, 4'h5, 4'hF, 2'd3, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 7, 4'h5, 4'h7, 2'd3, 1));
      tbl.push_back(mk(1, 1, 16'hABCD, 1, 4'hD, 4'hF, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 2, 4'hD, 4'hE, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 6, 4'hC, 4'hF, 2'd1, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 5, 4'hC, 4'hD, 2'd1, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 1, 4'h0, 4'hF, 2'd0, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 2, 4'h0, 4'hF, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 4'hD, 4'hF, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 2, 4'hD, 4'hE, 2'd0, 0));
      tbl.push_back(mk(0, 1, 16'h0050, 1, 4'h0, 4'hF, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 4'h0, 4'hF, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 2, 4'h0, 4'hE, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 8, 4'h5, 4'hD, 2'd1, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 8, 4'h0, LZ ? 4'hF : 4'hB, 2'd2, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 8, 4'h0, LZ ? 4'hF : 4'h7, 2'd3, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 5, 4'h0, LZ ? 4'hF : 4'h7, 2'd3, 1));
      tbl.push_back(mk(0, 1, 16'h0000, 1, 4'h0, 4'hF, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 4'h0, 4'hF, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 2, 4'h0, 4'hE, 2'd0, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 8, 4'h0, LZ ? 4'hF : 4'hD, 2'd1, 0));
      tbl.push_back(mk(1, 0, 16'h0000, 16, 4'h0, LZ ? 4'hF : 4'h7, 2'd3, 0));

      #1 rst = 1'b0;
      #2 check_outs("reset", 4'h0, 4'hF, 2'd0, 1'b0);
      step(2);
      @(negedge clk) rst = 1'b1;
      step(1);
      check_outs("post_reset_idle", 4'h0, 4'hF, 2'd0, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         bus.enable     = tbl[i].en;
         bus.load       = tbl[i].ld;
         bus.digit_data = tbl[i].dat;
         step(1);
         bus.load = 1'b0;
         if (tbl[i].adv > 1) step(tbl[i].adv - 1);
         check_outs($sformatf("row%0d", i), tbl[i].dec, tbl[i].an, tbl[i].idx, tbl[i].fd);
      end

      // frame_done cadence over two full frames
      bus.enable     = 1'b0;
      bus.load       = 1'b1;
      bus.digit_data = 16'h1234;
      step(1);
      bus.load   = 1'b0;
      bus.enable = 1'b1;
      step(1);
      pulses   = 0;
      first_fd = -1;
      last_fd  = -1;
      for (int c = 1; c <= 64; c++) begin
         step(1);
         if (bus.frame_done) begin
            pulses++;
            if (first_fd < 0) first_fd = c;
            last_fd = c;
         end
      end
      check("fd_pulse_count", 16'(pulses), 16'd2);
      check("fd_first_offset", 16'(first_fd), 16'd31);
      check("fd_last_offset", 16'(last_fd), 16'd63);

      // Reset asserted mid-SHOW of digit 2 acts without a clock edge
      step(18);
      check_outs("show_d2", 4'h2, 4'hB, 2'd2, 1'b0);
      #2 rst = 1'b0;
      #1 check_outs("async_reset", 4'h0, 4'hF, 2'd0, 1'b0);
      step(2);
      check_outs("reset_held", 4'h0, 4'hF, 2'd0, 1'b0);
      @(negedge clk) rst = 1'b1;
      step(1);
      check_outs("restart_blank", 4'h0, 4'hF, 2'd0, 1'b0);
      step(2);
      check_outs("restart_show", 4'h0, 4'hE, 2'd0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
